mic_adapt_sequencer: RTL and testbench
======================================

Name: mic_adapt_sequencer

Overview:
- Run-time controller for the adaptive microphone-cancellation filter.
- Sequences the filter through flush, warm-up and adaptation, and gates the coefficient-update enable (adj).
- Watches filter output for saturation, freezes adaptation on overload, and latches delay_lenght only while the filter is held in flush.
- Sits between the cntl register bank and the filter instance; same clock domain as the filter.

Parameters:
- FLUSH_CYCLES, 64: clock cycles filter reset is held asserted.
- WARMUP_SAMPLES, 1024: sample strobes with adj=0 before adaptation is enabled.
- SAT_THRESH, 16'sd8000: absolute output level counted as saturated.
- SAT_COUNT, 16: consecutive saturated samples that trigger freeze.
- HOLD_SAMPLES, 4096: sample strobes spent in FROZEN before retry (AUTO_RETRY_EN only).

Ports:
- clk, in, 1: system clock (filter clock).
- rst, in, 1: synchronous, active-low reset.
- start, in, 1: level; a rising edge (re)starts the sequence.
- stop, in, 1: level; while high, forces IDLE.
- sample_en, in, 1: one-cycle strobe per filter sample.
- filt_out, in, 16: signed filter output y(k).
- delay_req, in, 19: requested delay_lenght from the register bank.
- filt_rst, out, 1: active-high synchronous reset to the filter.
- adj, out, 1: coefficient update enable (0 = halt update).
- delay_lenght, out, 19: latched delay value driven to the filter.
- state_o, out, 3: current state encoding.
- freeze_cnt, out, 8: number of saturation freezes, saturating at 255.
- busy, out, 1: high in any state except IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, filt_rst=1, adj=0, delay_lenght=0, freeze_cnt=0, busy=0, all counters=0, start edge register=0.
- Start edge is detected as start & ~start_q, with start_q registered every cycle.
- State encoding: IDLE=0, FLUSH=1, WARMUP=2, ADAPT=3, FROZEN=4.
- IDLE: filt_rst=1, adj=0. A start edge with stop=0 goes to FLUSH next cycle.
- FLUSH:
  - filt_rst=1, adj=0.
  - delay_lenght<=delay_req on the first FLUSH cycle.
  - Counts FLUSH_CYCLES clocks, then goes to WARMUP; filt_rst deasserts on the same edge.
- WARMUP:
  - filt_rst=0, adj=0.
  - Counts sample_en strobes; on the WARMUP_SAMPLES-th strobe, goes to ADAPT.
- ADAPT:
  - filt_rst=0, adj=1.
  - On each sample_en, sat=(filt_out>=SAT_THRESH)||(filt_out<=-SAT_THRESH), compared as a 16-bit signed value.
  - A saturated sample increments sat_run; a non-saturated sample clears it to 0.
  - When sat_run reaches SAT_COUNT: go to FROZEN, adj=0 from the next cycle, freeze_cnt+1 (holds at 255).
- FROZEN:
  - filt_rst=0, adj=0.
  - Filter keeps running with its coefficients frozen.
  - Exit behaviour is set by the optional feature.
- Registered outputs: every output is registered and changes one cycle after the state transition edge.
- Latency: start edge to filt_rst falling is FLUSH_CYCLES+2 clocks.
- stop=1 has priority over everything except reset. It forces IDLE next cycle from any state (filt_rst=1, adj=0) and clears all counters; freeze_cnt is kept.
- A start edge in any non-IDLE state (with stop=0) restarts at FLUSH and relatches delay_lenght.
- delay_req changes outside FLUSH are ignored.
- sample_en is ignored in IDLE and FLUSH.
- Counters never wrap: each is sized to its parameter and cleared on state entry.
- Reset mid-operation (rst=0) aborts to the reset values on that edge regardless of state.

Optional Feature:
- Macro: MIC_ADAPT_AUTO_RETRY_EN.
- Defined:
  - FROZEN counts sample_en strobes and clears sat_run.
  - After HOLD_SAMPLES strobes, goes to ADAPT if the current sample is non-saturated.
  - Otherwise the hold count restarts.
- Undefined:
  - FROZEN is terminal until a start edge (to FLUSH) or stop (to IDLE).
  - No hold counter is implemented.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> filt_rst=1, adj=0, state_o=0, delay_lenght=0, freeze_cnt=0.
- Nominal sequence: delay_req=19'd1234, start pulse, sample_en every 4 clocks -> filt_rst falls FLUSH_CYCLES+2 clocks after start edge; delay_lenght=1234; adj rises one cycle after the 1024th strobe; state_o=3.
- Saturation freeze: in ADAPT, drive filt_out=-16'sd8000 for 16 strobes -> adj=0 and state_o=4 after the 16th strobe, freeze_cnt=1. Repeat with 15 saturated strobes then one at 16'sd100 -> no freeze.
- Stop priority: in WARMUP, assert stop and start simultaneously -> IDLE next cycle, filt_rst=1, busy=0. Deassert stop, pulse start -> FLUSH.
- Delay isolation: change delay_req to 19'd999 during ADAPT -> delay_lenght stays 1234. Restart via start edge -> 999.
- Auto retry (macro defined): after freeze, drive filt_out=0 -> ADAPT after 4096 strobes, adj=1. Macro undefined -> state_o stays 4 after 10000 strobes.

Source files
------------

// File: rtl/mic_adapt_sequencer.sv
// mic_adapt_sequencer: run-time controller for the adaptive mic-cancellation filter.
// Sequences IDLE -> FLUSH -> WARMUP -> ADAPT, freezes coefficient updates on sustained
// output saturation, and latches the filter delay only on entry to FLUSH.
// Optional build macro: MIC_ADAPT_AUTO_RETRY_EN (FROZEN retries ADAPT after a hold period).
module mic_adapt_sequencer #(
    parameter int unsigned       FLUSH_CYCLES   = 64,
    parameter int unsigned       WARMUP_SAMPLES = 1024,
    parameter logic signed [15:0] SAT_THRESH    = 16'sd8000,
    parameter int unsigned       SAT_COUNT      = 16
`ifdef MIC_ADAPT_AUTO_RETRY_EN
    ,
    parameter int unsigned       HOLD_SAMPLES   = 4096
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               sample_en,
    input  logic signed [15:0] filt_out,
    input  logic [18:0]        delay_req,
    output logic               filt_rst,
    output logic               adj,
    output logic [18:0]        delay_lenght,
    output logic [2:0]         state_o,
    output logic [7:0]         freeze_cnt,
    output logic               busy
);

    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned WARM_W  = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
    localparam int unsigned SAT_W   = $clog2(SAT_COUNT + 1);
`ifdef MIC_ADAPT_AUTO_RETRY_EN
    localparam int unsigned HOLD_W  = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_WARMUP = 3'd2,
        S_ADAPT  = 3'd3,
        S_FROZEN = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               start_q;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [FLUSH_W-1:0] flush_cnt_nxt;
    logic [WARM_W-1:0]  warm_cnt;
    logic [WARM_W-1:0]  warm_cnt_nxt;
    logic [SAT_W-1:0]   sat_run;
    logic [SAT_W-1:0]   sat_run_nxt;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_cnt_nxt;
`endif
    logic               freeze_pend;
    logic               start_edge_c;
    logic               sat_c;
    logic               freeze_evt_c;

    // Start rising edge and output saturation detect (signed 16-bit compare)
    always_comb begin
        start_edge_c = start & ~start_q;
        sat_c        = (filt_out >= SAT_THRESH) || (filt_out <= -SAT_THRESH);
    end

    // Next-state and counter update; stop beats start, start restarts from any state
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        warm_cnt_nxt  = warm_cnt;
        sat_run_nxt   = sat_run;
        freeze_evt_c  = 1'b0;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
        hold_cnt_nxt  = hold_cnt;
`endif
        if (stop) begin
            state_nxt     = S_IDLE;
            flush_cnt_nxt = '0;
            warm_cnt_nxt  = '0;
            sat_run_nxt   = '0;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
            hold_cnt_nxt  = '0;
`endif
        end else if (start_edge_c) begin
            state_nxt     = S_FLUSH;
            flush_cnt_nxt = '0;
            warm_cnt_nxt  = '0;
            sat_run_nxt   = '0;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
            hold_cnt_nxt  = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_IDLE;
                end
                S_FLUSH: begin
                    if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                        state_nxt     = S_WARMUP;
                        flush_cnt_nxt = '0;
                        warm_cnt_nxt  = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt + FLUSH_W'(1);
                    end
                end
                S_WARMUP: begin
                    if (sample_en) begin
                        if (warm_cnt == WARM_W'(WARMUP_SAMPLES - 1)) begin
                            state_nxt    = S_ADAPT;
                            warm_cnt_nxt = '0;
                            sat_run_nxt  = '0;
                        end else begin
                            warm_cnt_nxt = warm_cnt + WARM_W'(1);
                        end
                    end
                end
                S_ADAPT: begin
                    if (sample_en) begin
                        if (!sat_c) begin
                            sat_run_nxt = '0;
                        end else if (sat_run == SAT_W'(SAT_COUNT - 1)) begin
                            state_nxt    = S_FROZEN;
                            sat_run_nxt  = '0;
                            freeze_evt_c = 1'b1;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
                            hold_cnt_nxt = '0;
`endif
                        end else begin
                            sat_run_nxt = sat_run + SAT_W'(1);
                        end
                    end
                end
                S_FROZEN: begin
                    sat_run_nxt = '0;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
                    if (sample_en) begin
                        if (hold_cnt == HOLD_W'(HOLD_SAMPLES - 1)) begin
                            hold_cnt_nxt = '0;
                            if (!sat_c) begin
                                state_nxt = S_ADAPT;
                            end
                        end else begin
                            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end
`endif
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and start edge register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            flush_cnt <= '0;
            warm_cnt  <= '0;
            sat_run   <= '0;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            start_q   <= start;
            flush_cnt <= flush_cnt_nxt;
            warm_cnt  <= warm_cnt_nxt;
            sat_run   <= sat_run_nxt;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
            hold_cnt  <= hold_cnt_nxt;
`endif
        end
    end

    // Registered outputs follow the state one cycle later; delay latched on first FLUSH cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_rst     <= 1'b1;
            adj          <= 1'b0;
            busy         <= 1'b0;
            state_o      <= 3'd0;
            delay_lenght <= '0;
            freeze_cnt   <= '0;
            freeze_pend  <= 1'b0;
        end else begin
            filt_rst    <= (state == S_IDLE) || (state == S_FLUSH);
            adj         <= (state == S_ADAPT);
            busy        <= (state != S_IDLE);
            state_o     <= 3'(state);
            freeze_pend <= freeze_evt_c;
            if (freeze_pend && (freeze_cnt != 8'hFF)) begin
                freeze_cnt <= freeze_cnt + 8'd1;
            end
            if ((state == S_FLUSH) && (flush_cnt == '0)) begin
                delay_lenght <= delay_req;
            end
        end
    end

endmodule

// File: tb/tb_mic_adapt_sequencer.sv
// Directed + randomized bench for mic_adapt_sequencer with a sample-level reference model.
// Honors MIC_ADAPT_AUTO_RETRY_EN for the FROZEN exit checks.
module tb_mic_adapt_sequencer;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               sample_en;
    logic signed [15:0] filt_out;
    logic [18:0]        delay_req;
    logic               filt_rst;
    logic               adj;
    logic [18:0]        delay_lenght;
    logic [2:0]         state_o;
    logic [7:0]         freeze_cnt;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;
    int run = 0;
    bit frozen = 1'b0;
    int m_freeze = 0;

    mic_adapt_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_en(sample_en),
        .filt_out(filt_out), .delay_req(delay_req), .filt_rst(filt_rst), .adj(adj),
        .delay_lenght(delay_lenght), .state_o(state_o), .freeze_cnt(freeze_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [15:0] rand_val(input bit want_sat);
        int mag;
        mag = want_sat ? int'($urandom_range(32767, 8000)) : int'($urandom_range(7999, 0));
        return 16'(($urandom_range(1, 0) != 0) ? -mag : mag);
    endfunction

    // One ADAPT strobe: model tracks the consecutive saturated run from |y| >= 8000
    task automatic adapt_step(input logic signed [15:0] v);
        int iv;
        iv = int'(v);
        if (iv < 0) iv = -iv;
        run = (iv >= 8000) ? run + 1 : 0;
        filt_out  = v;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        filt_out  = 16'($urandom);
        tick();
        if (run >= 16) begin
            frozen = 1'b1;
            m_freeze++;
        end
        chk("adapt_state", 32'(state_o), frozen ? 32'd4 : 32'd3);
        chk("adapt_adj", 32'(adj), frozen ? 32'd0 : 32'd1);
        repeat ($urandom_range(2, 0)) tick();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; sample_en = 1'b0;
        filt_out = '0; delay_req = '0;

        // Reset
        repeat (3) tick();
        rst = 1'b1;
        chk("rst_filt_rst", 32'(filt_rst), 32'd1);
        chk("rst_adj", 32'(adj), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_delay", 32'(delay_lenght), 32'd0);
        chk("rst_freeze", 32'(freeze_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("idle_hold", 32'(state_o), 32'd0);

        // Nominal: start edge -> filt_rst falls 66 clocks later; sample_en ignored in FLUSH
        delay_req = 19'd1234;
        start = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            tick();
            if (i == 2) start = 1'b0;
            sample_en = (i < 64) ? 1'($urandom_range(1, 0)) : 1'b0;
            if (i == 2) begin
                chk("flush_state", 32'(state_o), 32'd1);
                chk("flush_busy", 32'(busy), 32'd1);
            end
            if (i == 65) chk("flush_last_rst", 32'(filt_rst), 32'd1);
            if (i == 66) chk("flush_rst_fall", 32'(filt_rst), 32'd0);
        end
        chk("warm_state", 32'(state_o), 32'd2);
        chk("nom_delay", 32'(delay_lenght), 32'd1234);

        // WARMUP: 1024 strobes with random spacing; saturated input must not matter here
        filt_out = -16'sd8000;
        for (int i = 1; i <= 1023; i++) begin
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            repeat ($urandom_range(3, 0)) tick();
        end
        tick();
        chk("warm_1023_state", 32'(state_o), 32'd2);
        chk("warm_1023_adj", 32'(adj), 32'd0);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("warm_1024_adj_lag", 32'(adj), 32'd0);
        tick();
        chk("adapt_adj_rise", 32'(adj), 32'd1);
        chk("adapt_state_entry", 32'(state_o), 32'd3);

        // ADAPT: delay_req change ignored; 15 saturated + one at 100 must not freeze
        delay_req = 19'd999;
        for (int i = 0; i < 15; i++) begin
            if (i == 0) adapt_step(16'sd8000);
            else if (i == 1) adapt_step(-16'sd8000);
            else adapt_step(rand_val(1'b1));
        end
        adapt_step(16'sd100);
        adapt_step(-16'sd7999);
        for (int i = 0; i < 60; i++) begin
            if (!frozen) adapt_step(rand_val($urandom_range(3, 0) != 0));
        end
        for (int i = 0; i < 17; i++) begin
            if (!frozen) adapt_step(-16'sd8000);
        end
        chk("frozen_flag", 32'(frozen), 32'd1);
        chk("freeze_cnt_1", 32'(freeze_cnt), 32'(m_freeze));
        chk("frozen_filt_rst", 32'(filt_rst), 32'd0);
        chk("frozen_busy", 32'(busy), 32'd1);
        chk("delay_isolated", 32'(delay_lenght), 32'd1234);

        // FROZEN exit behaviour
        filt_out = 16'sd0;
`ifdef MIC_ADAPT_AUTO_RETRY_EN
        sample_en = 1'b1;
        repeat (4095) tick();
        sample_en = 1'b0;
        tick();
        chk("hold_4095_state", 32'(state_o), 32'd4);
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        tick();
        chk("retry_state", 32'(state_o), 32'd3);
        chk("retry_adj", 32'(adj), 32'd1);
`else
        sample_en = 1'b1;
        repeat (10000) tick();
        sample_en = 1'b0;
        tick();
        chk("terminal_state", 32'(state_o), 32'd4);
        chk("terminal_adj", 32'(adj), 32'd0);
`endif

        // Restart via start edge relatches delay
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_state", 32'(state_o), 32'd1);
        chk("restart_delay", 32'(delay_lenght), 32'd999);
        chk("restart_filt_rst", 32'(filt_rst), 32'd1);
        repeat (64) tick();
        chk("restart_warm", 32'(state_o), 32'd2);
        chk("restart_rst_fall", 32'(filt_rst), 32'd0);

        // Stop priority over simultaneous start in WARMUP
        for (int i = 0; i < 10; i++) begin
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            tick();
        end
        stop = 1'b1;
        start = 1'b1;
        tick();
        tick();
        chk("stop_state", 32'(state_o), 32'd0);
        chk("stop_filt_rst", 32'(filt_rst), 32'd1);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_adj", 32'(adj), 32'd0);
        chk("stop_keep_freeze", 32'(freeze_cnt), 32'(m_freeze));
        stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_en = 1'($urandom_range(1, 0));
            tick();
        end
        sample_en = 1'b0;
        tick();
        chk("idle_no_edge", 32'(state_o), 32'd0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("stop_restart_state", 32'(state_o), 32'd1);
        chk("stop_restart_busy", 32'(busy), 32'd1);

        // Reset mid-operation
        repeat (10) tick();
        rst = 1'b0;
        tick();
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_filt_rst", 32'(filt_rst), 32'd1);
        chk("midrst_freeze", 32'(freeze_cnt), 32'd0);
        chk("midrst_delay", 32'(delay_lenght), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_idle", 32'(state_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
